// File: rtl/demux_1x4_stream.sv
// -----------------------------------------------------------------------------
// demux_1x4_stream
//
// Routes a valid/ready input stream to one of four output lanes selected by
// in_sel. Each lane owns a one-word holding register with its own valid flag
// and its own 8-bit delivered-word counter. A lane accepts a new word when it
// is empty or when its current word leaves on the same edge, so a continuously
// ready lane streams at one word per cycle. A stalled lane never blocks the
// other lanes.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_data    : word to route (w bits)
//   in_sel     : destination lane 0..3
//   in_valid   : in_data/in_sel are valid
//   in_ready   : the selected lane can take a word this cycle (combinational)
//   out0..out3 : lane holding registers (w bits each)
//   out_valid  : bit i set while lane i holds an undelivered word
//   out_ready  : bit i set when the lane i consumer takes the word
//   out_cnt    : lane i delivered-word count (mod 256) at bits [8i+7:8i]
// -----------------------------------------------------------------------------
module demux_1x4_stream #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [w-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [w-1:0] out0,
    output logic [w-1:0] out1,
    output logic [w-1:0] out2,
    output logic [w-1:0] out3,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [31:0]  out_cnt
);

    // Lane state
    logic [w-1:0] lane_data_r [4];
    logic [3:0]   lane_valid_r;
    logic [7:0]   lane_cnt_r   [4];

    // Per-cycle decode
    logic         in_ready_s;
    logic         accept_s;
    logic [3:0]   load_s;
    logic [3:0]   deliver_s;
    logic [3:0]   lane_valid_nxt_s;

    // Input handshake: the selected lane is free if empty or draining now.
    // While in reset every lane is about to be emptied, so report ready.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = (~lane_valid_r[in_sel]) | out_ready[in_sel];
        end
    end

    // Decode accept into a one-hot lane load and the per-lane deliveries.
    always_comb begin
        accept_s  = in_valid & in_ready_s;
        deliver_s = lane_valid_r & out_ready;
        load_s    = 4'b0000;
        case (in_sel)
            2'd0:    load_s = {3'b000, accept_s};
            2'd1:    load_s = {2'b00, accept_s, 1'b0};
            2'd2:    load_s = {1'b0, accept_s, 2'b00};
            2'd3:    load_s = {accept_s, 3'b000};
            default: load_s = 4'b0000;
        endcase
    end

    // Next valid flag per lane: a load wins over a delivery so that a
    // simultaneous drain-and-refill keeps the lane full with no bubble.
    always_comb begin
        lane_valid_nxt_s = lane_valid_r;
        for (int i = 0; i < 4; i++) begin
            if (load_s[i]) begin
                lane_valid_nxt_s[i] = 1'b1;
            end else if (deliver_s[i]) begin
                lane_valid_nxt_s[i] = 1'b0;
            end else begin
                lane_valid_nxt_s[i] = lane_valid_r[i];
            end
        end
    end

    // Lane valid flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_valid_r <= 4'b0000;
        end else begin
            lane_valid_r <= lane_valid_nxt_s;
        end
    end

    // Lane data registers: written only on a load, otherwise held (including
    // after delivery, when the contents are simply stale).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                lane_data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load_s[i]) begin
                    lane_data_r[i] <= in_data;
                end
            end
        end
    end

    // Delivered-word counters, free-running modulo 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                lane_cnt_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (deliver_s[i]) begin
                    lane_cnt_r[i] <= lane_cnt_r[i] + 8'd1;
                end
            end
        end
    end

    // Output mapping.
    always_comb begin
        in_ready  = in_ready_s;
        out0      = lane_data_r[0];
        out1      = lane_data_r[1];
        out2      = lane_data_r[2];
        out3      = lane_data_r[3];
        out_valid = lane_valid_r;
        out_cnt   = {lane_cnt_r[3], lane_cnt_r[2], lane_cnt_r[1], lane_cnt_r[0]};
    end

endmodule

// File: tb/tb_demux_1x4_stream.sv
module tb_demux_1x4_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out0, out1, out2, out3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_cnt;

    int n_cmp;
    int n_bad;

    demux_1x4_stream #(.w(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ordy;
        logic        e_irdy;   // in_ready before the edge
        logic [3:0]  e_ov;     // out_valid after the edge
        logic [31:0] e_cnt;    // out_cnt after the edge
        logic [1:0]  lane;     // lane whose data is checked after the edge
        logic [7:0]  e_data;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic logic [7:0] lane_out(input logic [1:0] l);
        case (l)
            2'd0:    return out0;
            2'd1:    return out1;
            2'd2:    return out2;
            2'd3:    return out3;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [1:0] sel,
                         input logic [7:0] d, input logic [3:0] ordy);
        rst       = r;
        in_valid  = iv;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);

        //           rst   iv    sel   data   ordy     irdy  ov       cnt            lane  data
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 8'h77, 4'b0000, 1'b1, 4'b0000, 32'h00000000, 2'd0, 8'h00};
        // basic routing, all consumers ready
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'hAA, 4'b1111, 1'b1, 4'b0001, 32'h00000000, 2'd0, 8'hAA};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 8'hBB, 4'b1111, 1'b1, 4'b0010, 32'h00000001, 2'd1, 8'hBB};
        vecs[3]  = '{1'b0, 1'b1, 2'd2, 8'hCC, 4'b1111, 1'b1, 4'b0100, 32'h00000101, 2'd2, 8'hCC};
        vecs[4]  = '{1'b0, 1'b1, 2'd3, 8'hDD, 4'b1111, 1'b1, 4'b1000, 32'h00010101, 2'd3, 8'hDD};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 8'h55, 4'b1111, 1'b1, 4'b0000, 32'h01010101, 2'd0, 8'hAA};
        // backpressure on lane 1
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 8'hBB, 4'b1101, 1'b1, 4'b0010, 32'h01010101, 2'd1, 8'hBB};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 8'h11, 4'b1101, 1'b0, 4'b0010, 32'h01010101, 2'd1, 8'hBB};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 8'h11, 4'b1101, 1'b0, 4'b0010, 32'h01010101, 2'd1, 8'hBB};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0010, 32'h01010201, 2'd1, 8'h11};
        vecs[10] = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h01010301, 2'd1, 8'h11};
        // lane 2 stalled must not block lane 0
        vecs[11] = '{1'b0, 1'b1, 2'd2, 8'hE2, 4'b1011, 1'b1, 4'b0100, 32'h01010301, 2'd2, 8'hE2};
        vecs[12] = '{1'b0, 1'b1, 2'd2, 8'hF0, 4'b1011, 1'b0, 4'b0100, 32'h01010301, 2'd2, 8'hE2};
        vecs[13] = '{1'b0, 1'b1, 2'd0, 8'h5A, 4'b1011, 1'b1, 4'b0101, 32'h01010301, 2'd0, 8'h5A};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1011, 1'b1, 4'b0100, 32'h01010302, 2'd2, 8'hE2};
        // two lanes delivering on the same edge
        vecs[15] = '{1'b0, 1'b1, 2'd0, 8'h66, 4'b1010, 1'b1, 4'b0101, 32'h01010302, 2'd0, 8'h66};
        vecs[16] = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0101, 1'b1, 4'b0000, 32'h01020303, 2'd0, 8'h66};

        tick();
        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].rst, vecs[v].iv, vecs[v].sel, vecs[v].data, vecs[v].ordy);
            #1;
            check($sformatf("v%0d in_ready", v), {31'd0, in_ready}, {31'd0, vecs[v].e_irdy});
            tick();
            check($sformatf("v%0d out_valid", v), {28'd0, out_valid}, {28'd0, vecs[v].e_ov});
            check($sformatf("v%0d out_cnt", v), out_cnt, vecs[v].e_cnt);
            check($sformatf("v%0d lane%0d data", v, vecs[v].lane),
                  {24'd0, lane_out(vecs[v].lane)}, {24'd0, vecs[v].e_data});
        end

        // Streaming 257 words into lane 3 from a clean reset, checking wrap.
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        tick();
        check("stream reset cnt", out_cnt, 32'h00000000);
        for (int k = 0; k <= 256; k++) begin
            logic [7:0] kb;
            logic [7:0] ek;
            kb = 8'(k);
            ek = 8'(k);     // deliveries completed after edge k
            drive(1'b0, 1'b1, 2'd3, kb, 4'b1000);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream in_ready k=%0d: got %b expected 1", k, in_ready);
            end
            tick();
            n_cmp++;
            if (out_valid !== 4'b1000 || out3 !== kb || out_cnt !== {ek, 24'h000000}) begin
                n_bad++;
                $display("FAIL stream k=%0d: got ov=%b out3=%h cnt=%h expected ov=1000 out3=%h cnt=%h",
                         k, out_valid, out3, out_cnt, kb, {ek, 24'h000000});
            end
        end
        check("stream cnt after 256", out_cnt, 32'h00000000);
        drive(1'b0, 1'b0, 2'd3, 8'h00, 4'b1000);
        tick();
        check("stream cnt wrap+1", out_cnt, 32'h01000000);
        check("stream drained", {28'd0, out_valid}, 32'd0);

        // Reset in the middle of operation with lanes 0 and 2 stalled.
        drive(1'b0, 1'b1, 2'd0, 8'hA0, 4'h0);
        tick();
        drive(1'b0, 1'b1, 2'd2, 8'hA2, 4'h0);
        tick();
        check("mid pre-reset ov", {28'd0, out_valid}, 32'h00000005);
        drive(1'b1, 1'b1, 2'd0, 8'hBB, 4'hF);
        #1;
        check("mid in_ready during rst", {31'd0, in_ready}, 32'd1);
        tick();
        check("mid rst ov", {28'd0, out_valid}, 32'd0);
        check("mid rst cnt", out_cnt, 32'd0);
        check("mid rst out0", {24'd0, out0}, 32'd0);
        check("mid rst out2", {24'd0, out2}, 32'd0);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check($sformatf("post-rst in_ready sel%0d", s), {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 1'b1, 2'd0, 8'hC3, 4'h0);
        tick();
        check("resume ov", {28'd0, out_valid}, 32'h00000001);
        check("resume out0", {24'd0, out0}, 32'h000000C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
